// File: rtl/vram_write_bridge.sv
// vram_write_bridge
// Queues processor stores that land in the text window and replays them into
// the single-port character RAM only during VGA blanking. Outside a granted
// replay cycle the RAM address port carries the VGA character fetch address.
module vram_write_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          TEXT_CHARS = 4096,
    parameter int          DEPTH      = 8,
    localparam int         PW         = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [31:0]   DataAdr,
    input  logic [31:0]   WriteData,
    input  logic [11:0]   char_index,
    input  logic          blank_b,
    output logic [11:0]   ram_address,
    output logic [7:0]    ram_data,
    output logic          ram_wren,
    output logic [PW-1:0] pending,
    output logic          busy,
    output logic          overflow,
    output logic [7:0]    drop_count
);

    // Index width into the entry storage; pointers carry one extra wrap bit.
    localparam int AW = PW - 1;

    // Window bounds widened to 33 bits so BASE_ADDR + TEXT_CHARS cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + 33'(TEXT_CHARS);

    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_count_q, drop_count_d;

    // Each entry is {12-bit window offset, 8-bit character}.
    logic [19:0]   entry_q [DEPTH];

    logic [32:0]   adr_ext;
    logic [31:0]   adr_off;
    logic [19:0]   new_entry;
    logic          hit;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [PW-1:0] occupancy;
    logic          fifo_empty;
    logic          fifo_full;
    logic [19:0]   head;
    logic          grant;
    logic          push;
    logic          pop;
    logic          drop;
    logic          last_pop;

    // Upper store bits carry nothing the text RAM can hold.
    logic          unused_bits;
    assign unused_bits = ^{WriteData[31:8], adr_off[31:12]};

    // Window decode and entry formation for the current store.
    assign adr_ext   = {1'b0, DataAdr};
    assign adr_off   = DataAdr - BASE_ADDR;
    assign hit       = MemWrite && (adr_ext >= WIN_LO) && (adr_ext < WIN_HI);
    assign new_entry = {adr_off[11:0], WriteData[7:0]};

    // FIFO status derived from the wrap-extended pointers.
    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign occupancy  = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (occupancy == '0);
    assign fifo_full  = (occupancy == PW'(DEPTH));
    assign head       = entry_q[rd_idx];

    // Grant is combinational on blank_b so the RAM is handed back to the VGA
    // fetch in the very cycle blanking ends.
    assign grant = (state_q == ST_DRAIN) && !blank_b && !fifo_empty;
    assign pop   = grant;

    // A full FIFO still accepts a store when the head leaves the same edge:
    // the slot being written is the one being vacated.
    assign push  = hit && (!fifo_full || pop);
    assign drop  = hit && fifo_full && !pop;

    // Pop that leaves the FIFO empty ends the drain early.
    assign last_pop = pop && (occupancy == PW'(1)) && !push;

    // Next-state logic for the pass/drain arbiter.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PASS: begin
                if (!blank_b && !fifo_empty) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (blank_b || last_pop) begin
                    state_d = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase
    end

    // Next-state for pointers and the drop bookkeeping.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    // State, pointers and drop counters; reset discards anything queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_PASS;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Entry storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[wr_idx] <= new_entry;
        end
    end

    // RAM port mux: head entry while granted, VGA fetch address otherwise.
    always_comb begin
        ram_address = char_index;
        ram_data    = 8'h00;
        ram_wren    = 1'b0;
        if (grant) begin
            ram_address = head[19:8];
            ram_data    = head[7:0];
            ram_wren    = 1'b1;
        end
    end

    assign pending    = occupancy;
    assign busy       = (state_q == ST_DRAIN);
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_vram_write_bridge.sv
// Directed bench for vram_write_bridge: store buffering, window decode,
// overflow, full push/pop, interrupted drain and reset during a drain.
module tb_vram_write_bridge;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [11:0] char_index;
    logic        blank_b;
    logic [11:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [3:0]  pending;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] log_q [$];
    logic [19:0] exp_q [$];

    vram_write_bridge #(
        .BASE_ADDR (32'h0000_1000),
        .TEXT_CHARS(4096),
        .DEPTH     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .char_index (char_index),
        .blank_b    (blank_b),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .pending    (pending),
        .busy       (busy),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every RAM write mid-cycle, one line per write.
    always @(negedge clk) begin
        if (ram_wren === 1'b1) begin
            log_q.push_back({ram_address, ram_data});
            $display("ram write addr=%h data=%h", ram_address, ram_data);
        end
    end

    // One store, presented for exactly one edge; entered and left at posedge+1.
    task automatic store(input logic [31:0] a, input logic [7:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = {24'hABCDEF, d};
        $display("store addr=%h data=%h", a, d);
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    // Blank for n edges, then return to active video for one edge.
    task automatic drain(input int n);
        blank_b = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        blank_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", pending); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b expected 0", ram_wren); end
        n_checks++; if (ram_address !== 12'h123) begin n_fail++; $display("FAIL reset_addr: got %h expected 123", ram_address); end
    endtask

    task automatic test_single_store;
        char_index = 12'h0AB;
        store(32'h0000_1005, 8'h41);
        n_checks++; if (pending !== 4'd1) begin n_fail++; $display("FAIL single_pending: got %0d expected 1", pending); end
        n_checks++; if (ram_address !== 12'h0AB) begin n_fail++; $display("FAIL single_passthru: got %h expected 0ab", ram_address); end
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL single_wren_idle: got %b expected 0", ram_wren); end
        blank_b = 1'b0;
        #1;
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL single_wren_pass: got %b expected 0", ram_wren); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        n_checks++; if (ram_wren !== 1'b1) begin n_fail++; $display("FAIL single_wren: got %b expected 1", ram_wren); end
        n_checks++; if (ram_address !== 12'h005) begin n_fail++; $display("FAIL single_addr: got %h expected 005", ram_address); end
        n_checks++; if (ram_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h expected 41", ram_data); end
        @(posedge clk); #1;
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL single_wren_done: got %b expected 0", ram_wren); end
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL single_pending_done: got %0d expected 0", pending); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_done: got %b expected 0", busy); end
        n_checks++; if (ram_address !== 12'h0AB) begin n_fail++; $display("FAIL single_addr_done: got %h expected 0ab", ram_address); end
        blank_b = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_window_edges;
        store(32'h0000_0FFF, 8'hEE);
        store(32'h0000_2000, 8'hDD);
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL window_miss_pending: got %0d expected 0", pending); end
        store(32'h0000_1000, 8'h11);
        store(32'h0000_1FFF, 8'h22);
        n_checks++; if (pending !== 4'd2) begin n_fail++; $display("FAIL window_hit_pending: got %0d expected 2", pending); end
        log_q.delete();
        exp_q = '{{12'h000, 8'h11}, {12'hFFF, 8'h22}};
        drain(4);
        n_checks++; if (log_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL window_write_count: got %0d expected %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL window_write[%0d]: got %h expected %h", i, log_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 10; i++) store(32'h0000_1100 + 32'(i), 8'h50 + 8'(i));
        n_checks++; if (pending !== 4'd8) begin n_fail++; $display("FAIL ovf_pending: got %0d expected 8", pending); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_checks++; if (drop_count !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_count: got %0d expected 2", drop_count); end
        log_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({12'h100 + 12'(i), 8'h50 + 8'(i)});
        drain(10);
        n_checks++; if (log_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovf_write_count: got %0d expected %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_write[%0d]: got %h expected %h", i, log_q[i], exp_q[i]); end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_full_push_pop;
        for (int i = 0; i < 8; i++) store(32'h0000_1200 + 32'(i), 8'h60 + 8'(i));
        n_checks++; if (pending !== 4'd8) begin n_fail++; $display("FAIL full_pending_pre: got %0d expected 8", pending); end
        log_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({12'h200 + 12'(i), 8'h60 + 8'(i)});
        exp_q.push_back({12'h300, 8'h77});
        blank_b = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ram_wren !== 1'b1) begin n_fail++; $display("FAIL full_granted: got %b expected 1", ram_wren); end
        store(32'h0000_1300, 8'h77);
        n_checks++; if (pending !== 4'd8) begin n_fail++; $display("FAIL full_pending_pushpop: got %0d expected 8", pending); end
        n_checks++; if (drop_count !== 8'd2) begin n_fail++; $display("FAIL full_no_drop: got %0d expected 2", drop_count); end
        repeat (10) @(posedge clk);
        #1;
        blank_b = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (log_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_write_count: got %0d expected %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_write[%0d]: got %h expected %h", i, log_q[i], exp_q[i]); end
        end
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL full_pending_end: got %0d expected 0", pending); end
    endtask

    task automatic test_mid_drain;
        char_index = 12'h3C4;
        for (int i = 0; i < 6; i++) store(32'h0000_1400 + 32'(i), 8'h80 + 8'(i));
        log_q.delete();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back({12'h400 + 12'(i), 8'h80 + 8'(i)});
        blank_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        blank_b = 1'b1;
        #1;
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL mid_wren_revoked: got %b expected 0", ram_wren); end
        n_checks++; if (ram_address !== 12'h3C4) begin n_fail++; $display("FAIL mid_addr_passthru: got %h expected 3c4", ram_address); end
        n_checks++; if (log_q.size() !== 3) begin n_fail++; $display("FAIL mid_first_count: got %0d expected 3", log_q.size()); end
        n_checks++; if (pending !== 4'd3) begin n_fail++; $display("FAIL mid_pending: got %0d expected 3", pending); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (log_q.size() !== 3) begin n_fail++; $display("FAIL mid_active_quiet: got %0d expected 3", log_q.size()); end
        drain(6);
        n_checks++; if (log_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL mid_write_count: got %0d expected %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_write[%0d]: got %h expected %h", i, log_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_drain;
        char_index = 12'h0F0;
        for (int i = 0; i < 3; i++) store(32'h0000_1500 + 32'(i), 8'h90 + 8'(i));
        blank_b = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ram_wren !== 1'b1) begin n_fail++; $display("FAIL rst_pre_wren: got %b expected 1", ram_wren); end
        reset = 1'b1;
        #1;
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren: got %b expected 0", ram_wren); end
        n_checks++; if (ram_address !== 12'h0F0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0f0", ram_address); end
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL rst_pending: got %0d expected 0", pending); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL rst_drop_count: got %0d expected 0", drop_count); end
        log_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (log_q.size() !== 0) begin n_fail++; $display("FAIL rst_no_writes: got %0d expected 0", log_q.size()); end
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL rst_pending_after: got %0d expected 0", pending); end
        blank_b = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        reset      = 1'b1;
        MemWrite   = 1'b0;
        DataAdr    = 32'h0;
        WriteData  = 32'h0;
        char_index = 12'h123;
        blank_b    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_single_store();
        test_window_edges();
        test_overflow();
        test_full_push_pop();
        test_mid_drain();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_write_bridge.md
# vram_write_bridge

Buffers processor stores aimed at the text window and replays them into the character RAM only while the VGA controller is blanking. Active-video character fetches therefore never collide with CPU writes. Sits between the processor's data-memory port (`MemWrite`/`DataAdr`/`WriteData`) and the text RAM's single address/data/wren port. During active video it passes the VGA `char_index` through unchanged.

## Interface
- `BASE_ADDR`, 32'h0000_1000, byte address of character 0 of the text window
- `TEXT_CHARS`, 4096, window size in characters (one byte address per character); must be ≤ 4096
- `DEPTH`, 8, write-FIFO entries; power of two, ≥ 2
- `clk`  in  1  system clock (same clock as processor, RAM and VGA)
- `reset`  in  1  asynchronous, active-high reset
- `MemWrite`  in  1  processor store strobe, one store per high cycle
- `DataAdr`  in  32  processor store byte address
- `WriteData`  in  32  processor store data; only bits [7:0] are used
- `char_index`  in  12  VGA character read address
- `blank_b`  in  1  VGA blanking flag; 0 = blanking interval
- `ram_address`  out  12  text RAM address
- `ram_data`  out  8  text RAM write data
- `ram_wren`  out  1  text RAM write enable
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy
- `busy`  out  1  FSM in DRAIN state
- `overflow`  out  1  sticky: at least one in-window store was dropped
- `drop_count`  out  8  dropped-store count, saturates at 255

## Operation
- **Window hit:** `MemWrite==1` and `BASE_ADDR ≤ DataAdr < BASE_ADDR+TEXT_CHARS` (unsigned 32-bit compare). Entry is {offset = (DataAdr−BASE_ADDR)[11:0], WriteData[7:0]}. Misses are ignored with no side effects.
- **FIFO:** circular, DEPTH entries, with read/write pointers one bit wider than the index. `pending` is the pointer difference.
- **Push:** on a hit, if not full or a pop occurs the same cycle.
- **Drop:** on a hit when full and no pop. `overflow`←1 and `drop_count` increments, saturating at 255.
- **FSM states:** PASS, DRAIN.
  - PASS→DRAIN at an edge where `blank_b==0` and `pending!=0`.
  - DRAIN→PASS at an edge where `blank_b==1`, or where the pop empties the FIFO with no simultaneous push.
  - Otherwise the state holds.
- **grant** = (state==DRAIN) && `blank_b==0` && `pending!=0`. It is combinational, so a rising `blank_b` revokes access in the same cycle and no active-video fetch is ever replaced.
- **grant=1:** `ram_address`=head offset, `ram_data`=head data, `ram_wren`=1. The entry pops at the next edge.
- **grant=0:** `ram_address`=`char_index`, `ram_data`=8'h00, `ram_wren`=0.
- **Ordering:** entries are written strictly in store order. Duplicate addresses are not merged.
- **Reset (any time, including mid-drain):**
  - Pointers cleared and pending stores discarded.
  - State=PASS.
  - `pending`=0, `busy`=0, `overflow`=0, `drop_count`=0.
  - `ram_wren`=0, `ram_address`=`char_index`.

## Timing
- **Push latency:** a store hit at edge N makes `pending` increment after edge N.
- **Minimum store-to-RAM latency:** 2 edges. Push at edge N, DRAIN entered at edge N+1 (if blanking), write performed at edge N+2.
- **Drain rate:** one entry per cycle while granted. A burst of k entries needs k consecutive blanking cycles after the DRAIN entry cycle.
- **Simultaneous push and pop:** `pending` is unchanged. A push into an empty FIFO is never popped in the same cycle.
- **Mid-drain blanking end:** remaining entries stay queued and resume in the next blanking interval.
- **Output reset values:** all registered outputs are 0 while `reset` is high. The combinational outputs follow the grant=0 rule above.

## Test plan
- **Single store, then blank:** store DataAdr=0x1005, WriteData=0x41 with `blank_b`=1. Expect `pending`=1 and `ram_address` tracking `char_index`. Then drop `blank_b`: one cycle later expect `busy`=1, then exactly one cycle of `ram_wren`=1 with addr 0x005, data 0x41, then `pending`=0 and `busy`=0.
- **Window edges:**
  - Stores to 0x0FFF and 0x2000: ignored, `pending` stays 0.
  - Stores to 0x1000 and 0x1FFF: accepted as offsets 0x000 and 0xFFF.
- **Overflow:** 10 in-window stores during active video with DEPTH=8. Expect `pending`=8, `overflow`=1, `drop_count`=2. The drain writes the first 8 stores in order.
- **Full with simultaneous push/pop:** FIFO full, blanking granted, store issued. Expect no drop, `pending` stays 8, and the new entry is written last.
- **Blank ends mid-drain:** 6 entries queued and blanking lasts 4 cycles. Expect 3 writes (entry cycle + 3 granted cycles) and `ram_wren`=0 in the first `blank_b`=1 cycle. The remaining 3 entries are written in the next blanking interval.
- **Reset mid-drain:** assert `reset` while `ram_wren`=1. Expect `ram_wren`=0 immediately, and `pending`, `busy`, `overflow` and `drop_count` all 0. No further writes occur after reset deasserts.
